edge_update_queue: RTL and testbench
====================================

// Module: edge_update_queue
// PURPOSE
// Host-facing ingress stage for the FOREX arbitrage engine. Collects edge-weight
// updates (src, dst, weight) written by the HPS over Avalon-MM and commits them
// into a FIFO. Presents them to the downstream graph container with a valid/ready
// handshake, so host writes never collide with an in-progress container pass.
// PARAMETERS
// PRED_W    5   bits per vertex index (src/dst)
// WEIGHT_W  32  edge weight width; also the Avalon data width; must be >= 2*PRED_W
// DEPTH     16  FIFO entries; power of two, >= 2
// PORTS
// clk         in   1               system clock
// reset       in   1               synchronous, active-high
// chipselect  in   1               Avalon slave select
// write       in   1               Avalon write strobe
// read        in   1               Avalon read strobe
// address     in   3               Avalon word address
// writedata   in   WEIGHT_W        Avalon write data
// readdata    out  WEIGHT_W        Avalon read data, registered (read latency 1)
// u_valid     out  1               head entry is valid
// u_ready     in   1               downstream accepts head entry
// u_src       out  PRED_W          head entry source vertex
// u_dst       out  PRED_W          head entry destination vertex
// u_e         out  WEIGHT_W        head entry weight
// BEHAVIOUR
// - Host access happens only when chipselect && write, or chipselect && read.
// - Host writes:
//   - addr 0: stage_src <= writedata[2*PRED_W-1:PRED_W]; stage_dst <= writedata[PRED_W-1:0].
//   - addr 1: stage_e <= writedata.
//   - addr 2 (commit, data ignored): push {stage_src, stage_dst, stage_e}.
//   - addr 3: clear sticky flags; writedata[0] clears overflow, writedata[1] clears bad_edge.
//   - addr 4-7: ignored.
// - Staging registers are not changed by commit, so the host can re-commit the same edge.
// - Commit rules:
//   - stage_src == stage_dst: no push; bad_edge <= 1.
//   - FIFO full and no pop this cycle: no push; overflow <= 1.
//   - FIFO full with a pop this cycle: push accepted; count stays DEPTH.
//   - Otherwise: push accepted.
//   - A commit and a clear of the same flag in one cycle cannot occur (one address per cycle).
// - Reads, registered: readdata takes its value on the cycle after chipselect && read.
//   - addr 0 status: [0] empty, [1] full, [2] overflow, [3] bad_edge,
//     [8 +: clog2(DEPTH+1)] count; other bits 0.
//   - addr 1: {stage_src, stage_dst}, zero-extended.
//   - addr 2: stage_e.
//   - Other addresses: 0.
// - Downstream interface:
//   - First-word-fall-through: u_valid = (count != 0). u_src, u_dst and u_e show the head entry.
//   - They are stable while u_valid && !u_ready.
//   - Pop occurs when u_valid && u_ready. u_ready while !u_valid has no effect.
//   - Push into an empty FIFO: u_valid rises on the cycle after the commit edge (latency 1).
//   - Simultaneous push and pop at count 1: the head advances to the new entry; u_valid stays 1.
// - Storage:
//   - Circular buffer with read and write pointers of clog2(DEPTH) bits; both wrap modulo DEPTH.
//   - count is a separate register, 0..DEPTH.
// - Reset (synchronous, takes priority over every other action):
//   - count = 0; pointers = 0; overflow = 0; bad_edge = 0.
//   - stage_src, stage_dst, stage_e = 0; readdata = 0; u_valid = 0.
//   - u_src, u_dst, u_e may show stale RAM contents while u_valid = 0.
//   - Reset mid-stream discards all queued entries with no pop handshake.
// TESTING
// 1. After reset, read addr 0 -> readdata 0x1 (empty), u_valid 0.
// 2. Write addr0=0x0043 (src 2, dst 3), addr1=0xFFFF_FF00, commit, u_ready=0 -> next cycle
//    u_valid 1, u_src 2, u_dst 3, u_e 0xFFFF_FF00; entry held for 5 cycles; u_ready=1 pops, then u_valid 0.
// 3. Commit DEPTH=16 entries (weights 0..15) with u_ready=0 -> status full=1, count 16.
//    A 17th commit sets overflow=1 and leaves count 16. Drain with u_ready=1:
//    weights 0..15 in order, one per cycle.
// 4. With count 16, u_ready=1 and a commit of weight 99 in the same cycle -> count stays 16,
//    overflow stays 0, and 99 is the last entry drained.
// 5. Stage src=dst=7 and commit -> count unchanged, bad_edge=1. Write addr3=0x2 -> bad_edge 0, overflow untouched.
// 6. Queue 3 entries, assert reset for 1 cycle mid-pop -> u_valid 0, count 0, and the first
//    entry committed after reset is the first one popped.

Source files
------------

// File: rtl/edge_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : edge_update_queue                                            |
// | Description : Host ingress queue for edge-weight updates. The host stages   |
// |               (src, dst, weight) over Avalon-MM and commits it into a       |
// |               circular FIFO. The FIFO head is offered downstream through a  |
// |               first-word-fall-through valid/ready interface.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module edge_update_queue #(
  parameter int PRED_W   = 5,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [WEIGHT_W-1:0] writedata,
  output logic [WEIGHT_W-1:0] readdata,
  output logic                u_valid,
  input  logic                u_ready,
  output logic [PRED_W-1:0]   u_src,
  output logic [PRED_W-1:0]   u_dst,
  output logic [WEIGHT_W-1:0] u_e
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 2 * PRED_W + WEIGHT_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [2:0]       ADDR_STAGE_ID = 3'd0;
  localparam logic [2:0]       ADDR_STAGE_E  = 3'd1;
  localparam logic [2:0]       ADDR_COMMIT   = 3'd2;
  localparam logic [2:0]       ADDR_CLEAR    = 3'd3;

  // Staging registers, FIFO storage and bookkeeping
  logic [PRED_W-1:0]   r_stage_src;
  logic [PRED_W-1:0]   r_stage_dst;
  logic [WEIGHT_W-1:0] r_stage_e;
  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_bad_edge;
  logic [WEIGHT_W-1:0] r_readdata;

  logic                w_host_wr;
  logic                w_host_rd;
  logic                w_commit;
  logic                w_clear;
  logic                w_same;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_ovf_set;
  logic [WEIGHT_W-1:0] w_status;
  logic [WEIGHT_W-1:0] w_rd_mux;

  assign w_host_wr = chipselect && write;
  assign w_host_rd = chipselect && read;
  assign w_commit  = w_host_wr && (address == ADDR_COMMIT);
  assign w_clear   = w_host_wr && (address == ADDR_CLEAR);
  assign w_same    = (r_stage_src == r_stage_dst);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);

  // A pop frees the slot being written when full, so full+pop still accepts.
  assign w_pop     = !w_empty && u_ready;
  assign w_push    = w_commit && !w_same && (!w_full || w_pop);
  assign w_ovf_set = w_commit && !w_same && w_full && !w_pop;

  // Head of the queue is shown combinationally (first-word-fall-through)
  assign u_valid             = !w_empty;
  assign {u_src, u_dst, u_e} = r_mem[r_rd_ptr];
  assign readdata            = r_readdata;

  // Host staging register writes; commit leaves staging intact for re-commits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_src <= '0;
      r_stage_dst <= '0;
      r_stage_e   <= '0;
    end else if (w_host_wr) begin
      case (address)
        ADDR_STAGE_ID: begin
          r_stage_src <= writedata[2*PRED_W-1:PRED_W];
          r_stage_dst <= writedata[PRED_W-1:0];
        end
        ADDR_STAGE_E: r_stage_e <= writedata;
        default: ;
      endcase
    end
  end

  // FIFO storage write; no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {r_stage_src, r_stage_dst, r_stage_e};
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky error flags; set and clear never coincide (one address per cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_bad_edge <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_clear && writedata[0]) begin
        r_overflow <= 1'b0;
      end
      if (w_commit && w_same) begin
        r_bad_edge <= 1'b1;
      end else if (w_clear && writedata[1]) begin
        r_bad_edge <= 1'b0;
      end
    end
  end

  // Read-side mux: status word and staging readback
  always_comb begin
    w_status              = '0;
    w_status[0]           = w_empty;
    w_status[1]           = w_full;
    w_status[2]           = r_overflow;
    w_status[3]           = r_bad_edge;
    w_status[8 +: CNT_W]  = r_count;
    w_rd_mux              = '0;
    case (address)
      3'd0:    w_rd_mux = w_status;
      3'd1:    w_rd_mux = WEIGHT_W'({r_stage_src, r_stage_dst});
      3'd2:    w_rd_mux = r_stage_e;
      default: w_rd_mux = '0;
    endcase
  end

  // Registered read data (latency 1); holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_host_rd) begin
      r_readdata <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_edge_update_queue                                         |
// | Description : Directed plus random bench for edge_update_queue, checked     |
// |               against a queue-based reference model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_edge_update_queue;

  localparam int PRED_W   = 5;
  localparam int WEIGHT_W = 32;
  localparam int DEPTH    = 16;

  typedef struct packed {
    logic [PRED_W-1:0]   s;
    logic [PRED_W-1:0]   d;
    logic [WEIGHT_W-1:0] e;
  } entry_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cs = 1'b0;
  logic                wr = 1'b0;
  logic                rd = 1'b0;
  logic [2:0]          addr = '0;
  logic [WEIGHT_W-1:0] wdata = '0;
  logic [WEIGHT_W-1:0] readdata;
  logic                u_valid;
  logic                u_ready = 1'b0;
  logic [PRED_W-1:0]   u_src;
  logic [PRED_W-1:0]   u_dst;
  logic [WEIGHT_W-1:0] u_e;

  int errors = 0;
  int checks = 0;

  // Reference model state
  entry_t              q[$];
  logic [PRED_W-1:0]   m_src = '0;
  logic [PRED_W-1:0]   m_dst = '0;
  logic [WEIGHT_W-1:0] m_e = '0;
  logic [WEIGHT_W-1:0] m_rd = '0;
  bit                  m_ovf = 1'b0;
  bit                  m_bad = 1'b0;

  edge_update_queue #(.PRED_W(PRED_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(cs), .write(wr), .read(rd),
    .address(addr), .writedata(wdata), .readdata(readdata),
    .u_valid(u_valid), .u_ready(u_ready), .u_src(u_src), .u_dst(u_dst), .u_e(u_e)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WEIGHT_W-1:0] model_status();
    int n;
    n = q.size();
    return WEIGHT_W'((n << 8) | (int'(m_bad) << 3) | (int'(m_ovf) << 2) |
                     (int'(n == DEPTH) << 1) | int'(n == 0));
  endfunction

  // Apply the behavioural rules to the model for the edge just taken
  task automatic model_step();
    bit pop;
    bit full_pre;
    pop      = (q.size() != 0) && u_ready;
    full_pre = (q.size() == DEPTH);
    if (reset) begin
      q.delete();
      m_src = '0; m_dst = '0; m_e = '0; m_rd = '0; m_ovf = 0; m_bad = 0;
    end else begin
      if (cs && rd) begin
        case (addr)
          3'd0:    m_rd = model_status();
          3'd1:    m_rd = WEIGHT_W'({m_src, m_dst});
          3'd2:    m_rd = m_e;
          default: m_rd = '0;
        endcase
      end
      if (pop) void'(q.pop_front());
      if (cs && wr) begin
        case (addr)
          3'd0: begin m_src = wdata[2*PRED_W-1:PRED_W]; m_dst = wdata[PRED_W-1:0]; end
          3'd1: m_e = wdata;
          3'd2: begin
            if (m_src == m_dst) m_bad = 1;
            else if (full_pre && !pop) m_ovf = 1;
            else q.push_back('{s: m_src, d: m_dst, e: m_e});
          end
          3'd3: begin
            if (wdata[0]) m_ovf = 0;
            if (wdata[1]) m_bad = 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("u_valid", 64'(u_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("head", 64'({u_src, u_dst, u_e}), 64'(q[0]));
    check("readdata", 64'(readdata), 64'(m_rd));
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [WEIGHT_W-1:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; wdata = d;
    tick();
    cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    cs = 1; rd = 1; wr = 0; addr = a;
    tick();
    cs = 0; rd = 0;
  endtask

  function automatic logic [WEIGHT_W-1:0] ids(input int s, input int d);
    return WEIGHT_W'((s << PRED_W) | d);
  endfunction

  initial begin
    // 1: reset state
    reset = 1; tick(); tick();
    reset = 0;
    bus_read(3'd0);
    check("reset_status", 64'(readdata), 64'h1);
    check("reset_valid", 64'(u_valid), 64'h0);

    // 2: single entry, hold, pop
    bus_write(3'd0, 32'h0000_0043);
    bus_write(3'd1, 32'hFFFF_FF00);
    bus_write(3'd2, 32'h0);
    check("push_valid", 64'(u_valid), 64'h1);
    check("push_src", 64'(u_src), 64'h2);
    check("push_dst", 64'(u_dst), 64'h3);
    check("push_e", 64'(u_e), 64'hFFFF_FF00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_e", 64'(u_e), 64'hFFFF_FF00);
    end
    u_ready = 1; tick();
    check("popped_valid", 64'(u_valid), 64'h0);
    u_ready = 0;

    // 3: fill, overflow, bad edge while full, drain in order
    bus_write(3'd0, ids(1, 2));
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(3'd1, WEIGHT_W'(i));
      bus_write(3'd2, 32'h0);
    end
    bus_read(3'd0);
    check("full_status", 64'(readdata), 64'h1002);
    bus_write(3'd2, 32'h0);
    bus_read(3'd0);
    check("overflow_status", 64'(readdata), 64'h1006);
    bus_write(3'd0, ids(7, 7));
    bus_write(3'd2, 32'h0);
    bus_read(3'd0);
    check("bad_status", 64'(readdata), 64'h100E);
    bus_write(3'd3, 32'h2);
    bus_read(3'd0);
    check("clear_bad_status", 64'(readdata), 64'h1006);
    u_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 64'(u_e), 64'(i));
      tick();
    end
    check("drained_valid", 64'(u_valid), 64'h0);
    u_ready = 0;
    bus_write(3'd3, 32'h1);
    bus_read(3'd0);
    check("clear_ovf_status", 64'(readdata), 64'h1);

    // 4: push while full with a simultaneous pop
    bus_write(3'd0, ids(1, 2));
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(3'd1, WEIGHT_W'(i));
      bus_write(3'd2, 32'h0);
    end
    bus_write(3'd1, 32'd99);
    u_ready = 1;
    bus_write(3'd2, 32'h0);
    u_ready = 0;
    bus_read(3'd0);
    check("full_pop_push_status", 64'(readdata), 64'h1002);
    u_ready = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain_last", 64'(u_e), (i == DEPTH) ? 64'd99 : 64'(i));
      tick();
    end
    u_ready = 0;

    // 6: reset mid-pop discards the queue
    for (int i = 0; i < 3; i++) bus_write(3'd2, 32'h0);
    u_ready = 1; tick();
    reset = 1; tick();
    check("reset_midpop_valid", 64'(u_valid), 64'h0);
    reset = 0; u_ready = 0;
    bus_read(3'd0);
    check("reset_midpop_status", 64'(readdata), 64'h1);
    bus_write(3'd0, ids(4, 5));
    bus_write(3'd1, 32'h0000_0ABC);
    bus_write(3'd2, 32'h0);
    check("after_reset_head_e", 64'(u_e), 64'hABC);
    check("after_reset_head_src", 64'(u_src), 64'h4);
    u_ready = 1; tick(); u_ready = 0;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset   = ($urandom_range(99) == 0);
      cs      = ($urandom_range(3) != 0);
      wr      = $urandom_range(1);
      rd      = $urandom_range(1);
      addr    = ($urandom_range(2) == 0) ? 3'd2 : 3'($urandom_range(7));
      wdata   = $urandom;
      if ($urandom_range(7) == 0) wdata[PRED_W-1:0] = wdata[2*PRED_W-1:PRED_W];
      u_ready = ($urandom_range(3) == 0);
      tick();
    end
    reset = 0; cs = 0; wr = 0; rd = 0; u_ready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
